multicycle_ctrl: RTL

Control-unit FSM that sequences the multicycle RISC-V datapath (PC, IR, register file, ALU, data memory) one micro-step per clock. It decodes the latched instruction fields and drives every write strobe, mux select and ALU operation code. It also exposes its state code and a retired-instruction counter for board-level single-step display.

---
 rtl/multicycle_ctrl.sv | 274 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
//
// Control unit for a multicycle RISC-V datapath (PC, IR, register file, ALU,
// data memory). One micro-step per clock: the FSM decodes the latched IR fields
// and drives every write strobe, mux select and ALU operation code. The current
// state code and a retired-instruction counter are exported for single-step
// display on a board.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   en         step enable; low freezes the FSM and suppresses all pulses
//   opcode     IR[6:0]
//   funct3     IR[14:12]
//   funct7_5   IR[30]
//   zf         ALU zero flag (combinational from the current ALU op)
//   pc_write   PC write strobe
//   pc0_write  PC0 (address of current instruction) write strobe
//   ir_write   IR write strobe
//   reg_write  register file write strobe
//   mem_write  data memory write strobe
//   pc_s       next-PC select: 0 PC+4, 1 PC0+imm, 2 {F[31:1],1'b0}
//   alu_a_s    ALU A select: 0 rs1, 1 PC0
//   alu_b_s    ALU B select: 0 rs2, 1 imm
//   w_data_s   register write data select: 0 F, 1 imm, 2 mem data reg, 3 PC
//   alu_op     {sub/arith bit, funct3}
//   state      current state code
//   illegal    one-cycle pulse on an unsupported opcode/funct3
//   retire     one-cycle pulse in the last state of every instruction
//   inst_cnt   retired-instruction count (wraps)
// -----------------------------------------------------------------------------
module multicycle_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic        funct7_5,
  input  logic        zf,
  output logic        pc_write,
  output logic        pc0_write,
  output logic        ir_write,
  output logic        reg_write,
  output logic        mem_write,
  output logic [1:0]  pc_s,
  output logic        alu_a_s,
  output logic        alu_b_s,
  output logic [1:0]  w_data_s,
  output logic [3:0]  alu_op,
  output logic [3:0]  state,
  output logic        illegal,
  output logic        retire,
  output logic [31:0] inst_cnt
);

  typedef enum logic [3:0] {
    StIdle     = 4'd0,
    StFetch    = 4'd1,
    StDecode   = 4'd2,
    StRExec    = 4'd3,
    StWb       = 4'd4,
    StIExec    = 4'd5,
    StLui      = 4'd6,
    StMemAddr  = 4'd7,
    StMemRead  = 4'd8,
    StMemWb    = 4'd9,
    StMemWrite = 4'd10,
    StJal      = 4'd11,
    StJalr     = 4'd12,
    StBranch   = 4'd13,
    StBrDecide = 4'd14,
    StUnused   = 4'd15
  } state_e;

  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpBranch = 7'b1100011;

  localparam logic [2:0] F3Beq  = 3'b000;
  localparam logic [2:0] F3Bne  = 3'b001;
  localparam logic [2:0] F3Srx  = 3'b101;

  localparam logic [3:0] AluAdd = 4'b0000;
  localparam logic [3:0] AluSub = 4'b1000;

  state_e      state_q, state_d;
  logic [31:0] inst_cnt_q;

  // Ungated versions of the pulse outputs; gated by en and rst below.
  logic pc_write_raw;
  logic pc0_write_raw;
  logic ir_write_raw;
  logic reg_write_raw;
  logic mem_write_raw;
  logic illegal_raw;
  logic retire_raw;

  // Pulses only fire on a step that will actually be taken.
  logic act;
  assign act = en & ~rst;

  always_comb begin
    state_d       = state_q;
    pc_write_raw  = 1'b0;
    pc0_write_raw = 1'b0;
    ir_write_raw  = 1'b0;
    reg_write_raw = 1'b0;
    mem_write_raw = 1'b0;
    illegal_raw   = 1'b0;
    retire_raw    = 1'b0;
    pc_s          = 2'd0;
    alu_a_s       = 1'b0;
    alu_b_s       = 1'b0;
    w_data_s      = 2'd0;
    alu_op        = AluAdd;

    case (state_q)
      StIdle: begin
        state_d = StFetch;
      end

      StFetch: begin
        ir_write_raw  = 1'b1;
        pc0_write_raw = 1'b1;
        pc_write_raw  = 1'b1;
        pc_s          = 2'd0;
        state_d       = StDecode;
      end

      StDecode: begin
        case (opcode)
          OpReg:           state_d = StRExec;
          OpImm:           state_d = StIExec;
          OpLui:           state_d = StLui;
          OpLoad, OpStore: state_d = StMemAddr;
          OpJal:           state_d = StJal;
          OpJalr:          state_d = StJalr;
          OpBranch:        state_d = StBranch;
          default: begin
            illegal_raw = 1'b1;
            state_d     = StFetch;
          end
        endcase
      end

      StRExec: begin
        alu_a_s = 1'b0;
        alu_b_s = 1'b0;
        alu_op  = {funct7_5, funct3};
        state_d = StWb;
      end

      StIExec: begin
        // Only the shift-right pair uses IR[30] to pick arithmetic vs logical;
        // for every other immediate op that bit belongs to the immediate.
        alu_b_s = 1'b1;
        alu_op  = {(funct3 == F3Srx) ? funct7_5 : 1'b0, funct3};
        state_d = StWb;
      end

      StWb: begin
        reg_write_raw = 1'b1;
        w_data_s      = 2'd0;
        retire_raw    = 1'b1;
        state_d       = StFetch;
      end

      StLui: begin
        reg_write_raw = 1'b1;
        w_data_s      = 2'd1;
        retire_raw    = 1'b1;
        state_d       = StFetch;
      end

      StMemAddr: begin
        alu_b_s = 1'b1;
        alu_op  = AluAdd;
        state_d = (opcode == OpLoad) ? StMemRead : StMemWrite;
      end

      StMemRead: begin
        state_d = StMemWb;
      end

      StMemWb: begin
        reg_write_raw = 1'b1;
        w_data_s      = 2'd2;
        retire_raw    = 1'b1;
        state_d       = StFetch;
      end

      StMemWrite: begin
        // Keep the address computation on the ALU while memory is written.
        alu_b_s       = 1'b1;
        alu_op        = AluAdd;
        mem_write_raw = 1'b1;
        retire_raw    = 1'b1;
        state_d       = StFetch;
      end

      StJal: begin
        reg_write_raw = 1'b1;
        w_data_s      = 2'd3;
        pc_write_raw  = 1'b1;
        pc_s          = 2'd1;
        retire_raw    = 1'b1;
        state_d       = StFetch;
      end

      StJalr: begin
        alu_b_s       = 1'b1;
        alu_op        = AluAdd;
        reg_write_raw = 1'b1;
        w_data_s      = 2'd3;
        pc_write_raw  = 1'b1;
        pc_s          = 2'd2;
        retire_raw    = 1'b1;
        state_d       = StFetch;
      end

      StBranch: begin
        alu_op = AluSub;
        if (funct3 == F3Beq || funct3 == F3Bne) begin
          state_d = StBrDecide;
        end else begin
          illegal_raw = 1'b1;
          state_d     = StFetch;
        end
      end

      StBrDecide: begin
        alu_op       = AluSub;
        pc_write_raw = (funct3 == F3Beq) ? zf : ~zf;
        pc_s         = 2'd1;
        retire_raw   = 1'b1;
        state_d      = StFetch;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign pc_write  = act & pc_write_raw;
  assign pc0_write = act & pc0_write_raw;
  assign ir_write  = act & ir_write_raw;
  assign reg_write = act & reg_write_raw;
  assign mem_write = act & mem_write_raw;
  assign illegal   = act & illegal_raw;
  assign retire    = act & retire_raw;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      inst_cnt_q <= 32'd0;
    end else if (en) begin
      state_q <= state_d;
      if (retire) begin
        inst_cnt_q <= inst_cnt_q + 32'd1;
      end
    end
  end

  assign state    = state_q;
  assign inst_cnt = inst_cnt_q;

endmodule
